vlc_seq_ctrl: RTL and testbench

- Parametrised successor to the 3+3 lamp vehicle lighting controller.
- Drives LAMPS sequential turn-signal lamps per side, with a chase pattern, hazard flashing and a steady brake override.
- An internal prescaler sets the step rate.
- Sits between the driver-input pins and the lamp outputs of the top-level tile.

---
 rtl/vlc_pkg.sv | 38 +++
 rtl/vlc_tick_gen.sv | 33 +++
 rtl/vlc_seq_ctrl.sv | 103 ++++++++++
 tb/tb_vlc_seq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared types and helpers for the sequential vehicle lamp controller.
// Holds the mode encoding, the input priority decode and the chase mask builder.
package vlc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } vlc_mode_t;

    // Both indicators together are treated the same as a hazard request.
    function automatic vlc_mode_t decode_mode(input logic hazard,
                                              input logic turn_left,
                                              input logic turn_right);
        vlc_mode_t m;
        if (hazard || (turn_left && turn_right)) begin
            m = HAZARD;
        end else if (turn_left) begin
            m = LEFT;
        end else if (turn_right) begin
            m = RIGHT;
        end else begin
            m = IDLE;
        end
        return m;
    endfunction

    // Bit k set iff k < step; callers slice the low LAMPS bits.
    function automatic logic [7:0] thermo_mask(input logic [3:0] step);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (4'(i) < step);
        end
        return m;
    endfunction

endpackage

// File: rtl/vlc_tick_gen.sv
// Animation step prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// A synchronous clear restarts the count so a new sequence gets a full first step.
module vlc_tick_gen #(
    parameter int TICK_DIV = 1000000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/vlc_seq_ctrl.sv
// Sequential turn-signal / hazard / brake lamp controller for LAMPS lamps per side.
// Lamps are registered from the next-state decode, so inputs show one edge after sampling.
module vlc_seq_ctrl
    import vlc_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1000000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             turn_left,
    input  logic             turn_right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] left_lamp,
    output logic [LAMPS-1:0] right_lamp,
    output logic [1:0]       mode,
    output logic             step_tick
);

    localparam int STEP_W = $clog2(LAMPS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);

    vlc_mode_t         mode_q, mode_d, dec_mode;
    logic [STEP_W-1:0] step_q, step_d;
    logic              phase_q, phase_d;
    logic              mode_change;
    logic              tick;
    logic [CNT_W-1:0]  tick_count;
    logic [7:0]        mask_full;
    logic [LAMPS-1:0]  chase_mask, brake_mask;
    logic [LAMPS-1:0]  left_d, right_d;

    assign dec_mode    = decode_mode(hazard, turn_left, turn_right);
    assign mode_change = (dec_mode != mode_q);

    // Prescaler restarts on any mode change and is parked at zero while idle.
    vlc_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (mode_q != IDLE),
        .clr   (mode_change || (dec_mode == IDLE)),
        .tick  (tick),
        .count (tick_count)
    );

    always_comb begin
        mode_d  = dec_mode;
        step_d  = step_q;
        phase_d = phase_q;
        if (mode_change) begin
            step_d  = ((dec_mode == LEFT) || (dec_mode == RIGHT)) ? STEP_W'(1) : '0;
            phase_d = (dec_mode == HAZARD);
        end else if (tick) begin
            case (mode_q)
                LEFT, RIGHT: step_d  = (step_q == STEP_LAST) ? '0 : STEP_W'(step_q + 1'b1);
                HAZARD:      phase_d = ~phase_q;
                default:     ;
            endcase
        end
    end

    always_comb begin
        mask_full  = thermo_mask(4'(step_d));
        chase_mask = mask_full[LAMPS-1:0];
        brake_mask = brake ? '1 : '0;
        left_d     = brake_mask;
        right_d    = brake_mask;
        case (mode_d)
            LEFT:   left_d  = chase_mask;
            RIGHT:  right_d = chase_mask;
            HAZARD: begin
                left_d  = phase_d ? '1 : '0;
                right_d = phase_d ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= IDLE;
            step_q     <= '0;
            phase_q    <= 1'b0;
            left_lamp  <= '0;
            right_lamp <= '0;
        end else begin
            mode_q     <= mode_d;
            step_q     <= step_d;
            phase_q    <= phase_d;
            left_lamp  <= left_d;
            right_lamp <= right_d;
        end
    end

    assign mode      = mode_q;
    assign step_tick = tick;

endmodule

// File: tb/tb_vlc_seq_ctrl.sv
// Self-checking bench for vlc_seq_ctrl (LAMPS=3, TICK_DIV=4) against a cycles-since-entry model.
// Directed scenarios first, then randomized held input vectors.
module tb_vlc_seq_ctrl;

    localparam int LAMPS    = 3;
    localparam int TICK_DIV = 4;
    localparam int ALL_ON   = (1 << LAMPS) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             turn_left = 1'b1;
    logic             turn_right = 1'b1;
    logic             hazard = 1'b1;
    logic             brake = 1'b1;
    logic [LAMPS-1:0] left_lamp, right_lamp;
    logic [1:0]       mode;
    logic             step_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current mode (0..3) and edges elapsed since that mode was entered.
    int m_mode = 0;
    int m_n    = 0;

    always #5 clk = ~clk;

    vlc_seq_ctrl #(
        .LAMPS    (LAMPS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .hazard     (hazard),
        .brake      (brake),
        .left_lamp  (left_lamp),
        .right_lamp (right_lamp),
        .mode       (mode),
        .step_tick  (step_tick)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int req_mode();
        if (hazard || (turn_left && turn_right)) return 3;
        if (turn_left) return 1;
        if (turn_right) return 2;
        return 0;
    endfunction

    // Expected lamps for the mode/elapsed-edge state and brake level sampled at the edge.
    logic [7:0] e_left, e_right;
    logic       e_brake;

    task automatic model_edge();
        int r;
        r = req_mode();
        if (r != m_mode) begin
            m_mode = r;
            m_n    = 0;
        end else begin
            m_n++;
        end
        e_brake = brake;
    endtask

    task automatic compare_all(input string tag);
        int step, phase, bmask;
        step    = ((m_n / TICK_DIV) + 1) % (LAMPS + 1);
        phase   = ((m_n / TICK_DIV) % 2 == 0) ? 1 : 0;
        bmask   = e_brake ? ALL_ON : 0;
        e_left  = 8'(bmask);
        e_right = 8'(bmask);
        if (m_mode == 1) e_left  = 8'((1 << step) - 1);
        if (m_mode == 2) e_right = 8'((1 << step) - 1);
        if (m_mode == 3) begin
            e_left  = phase ? 8'(ALL_ON) : 8'h00;
            e_right = e_left;
        end
        check({tag, ".left"},  8'(left_lamp),  e_left);
        check({tag, ".right"}, 8'(right_lamp), e_right);
        check({tag, ".mode"},  8'(mode),       8'(m_mode));
        check({tag, ".tick"},  8'(step_tick),
              8'((m_mode != 0) && (m_n % TICK_DIV == TICK_DIV - 1)));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst) begin
            m_mode = 0;
            m_n    = 0;
            e_brake = 1'b0;
        end else begin
            model_edge();
        end
        #1;
        compare_all(tag);
    endtask

    task automatic set_in(input logic l, input logic r, input logic h, input logic b);
        turn_left  = l;
        turn_right = r;
        hazard     = h;
        brake      = b;
    endtask

    initial begin
        e_brake = 1'b0;
        // Reset held with every request active.
        repeat (3) cyc("reset");
        #3;
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (4) cyc("idle");

        // Left chase.
        set_in(1, 0, 0, 0);
        cyc("left_first");
        check("left_first_const", 8'(left_lamp), 8'h01);
        repeat (15) cyc("left");

        // Brake during chase lights the inactive side; drop it mid-chase.
        brake = 1'b1;
        repeat (6) cyc("left_brake");
        check("left_brake_const", 8'(right_lamp), 8'(ALL_ON));
        brake = 1'b0;
        repeat (5) cyc("left_unbrake");

        // Hazard, with brake toggled partway (ignored).
        set_in(0, 0, 1, 0);
        repeat (6) cyc("hazard");
        brake = 1'b1;
        repeat (6) cyc("hazard_brake");
        set_in(0, 0, 0, 0);
        cyc("hazard_off");

        // Both indicators behave as hazard.
        set_in(1, 1, 0, 0);
        cyc("both_first");
        check("both_mode_const", 8'(mode), 8'd3);
        repeat (10) cyc("both");

        // Left to step 2, then switch to right: prescaler restarts.
        set_in(0, 0, 0, 0);
        cyc("pre_switch");
        set_in(1, 0, 0, 0);
        repeat (5) cyc("to_step2");
        check("step2_const", 8'(left_lamp), 8'h03);
        set_in(0, 1, 0, 0);
        cyc("switch_right");
        check("switch_right_const", 8'(right_lamp), 8'h01);
        repeat (9) cyc("right");

        // Asynchronous reset between edges blanks lamps immediately.
        #3;
        rst = 1'b1;
        #1;
        m_mode = 0;
        m_n    = 0;
        check("async_rst.left",  8'(left_lamp),  8'h00);
        check("async_rst.right", 8'(right_lamp), 8'h00);
        check("async_rst.mode",  8'(mode),       8'h00);
        #2;
        rst = 1'b0;
        cyc("after_rst");
        check("after_rst_const", 8'(right_lamp), 8'h01);
        repeat (6) cyc("after_rst_run");

        // Randomized held input vectors.
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            len = int'($urandom_range(1, 14));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) brake = ~brake;
                cyc("random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
